// File: rtl/ram_stream_loader_pkg.sv
// Shared constants for the RAM stream loader: FSM encodings and frame helpers.
package ram_stream_loader_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LEN0  = 3'd1;
  localparam logic [2:0] ST_LEN1  = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;
  localparam logic [2:0] ST_CSUM  = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;
  localparam logic [2:0] ST_ERROR = 3'd7;

  localparam int LEN_FIELD_BYTES = 2;
  localparam int CSUM_FIELD_BYTES = 1;

  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/ram_stream_loader_byte_packer.sv
// Little-endian byte-to-word packer: first byte shifted in lands in the word LSBs.
module ram_stream_loader_byte_packer
  import ram_stream_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  shift_en,
  input  logic [7:0]            byte_in,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_ready
);

  localparam int BPW   = bytes_per_word(DATA_WIDTH);
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] word_q;

  // word already contains the in-flight byte so the final byte can be written without a bubble
  always_comb begin
    word = word_q;
    word[int'(idx)*8 +: 8] = byte_in;
    word_ready = shift_en && (idx == IDX_W'(BPW - 1));
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      idx    <= '0;
      word_q <= '0;
    end else if (shift_en) begin
      word_q[int'(idx)*8 +: 8] <= byte_in;
      idx <= word_ready ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/ram_stream_loader.sv
// Loads a framed, checksummed byte stream into consecutive RAM words and holds the CPU until done.
module ram_stream_loader
  import ram_stream_loader_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12,
  parameter int DEPTH         = 4096,
  parameter int BASE_ADDR     = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     ram_wEn,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_dataIn,
  output logic                     cpu_hold,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [15:0]              words_loaded,
  output logic [2:0]               fsm_state
);

  // Handshake: a byte moves when in_valid & in_ready are both high at a rising edge;
  // in_ready depends only on state, never on in_valid.

  localparam logic [16:0] MAX_WORDS = 17'(DEPTH - BASE_ADDR);

  logic [2:0]            state;
  logic [15:0]           len;
  logic [7:0]            checksum;
  logic                  accept;
  logic                  arm;
  logic                  shift_en;
  logic                  word_ready;
  logic [DATA_WIDTH-1:0] word;
  logic [15:0]           len_next;
  logic [15:0]           words_next;

  assign accept     = in_valid && in_ready;
  assign arm        = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
  assign shift_en   = accept && (state == ST_DATA);
  assign len_next   = {in_data, len[7:0]};
  assign words_next = words_loaded + 16'd1;

  ram_stream_loader_byte_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (arm),
    .shift_en   (shift_en),
    .byte_in    (in_data),
    .word       (word),
    .word_ready (word_ready)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      len          <= '0;
      words_loaded <= '0;
      checksum     <= '0;
      ram_addr     <= ADDRESS_WIDTH'(BASE_ADDR);
      ram_dataIn   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (arm) begin
            state        <= ST_LEN0;
            words_loaded <= '0;
            checksum     <= '0;
          end
        end
        ST_LEN0: begin
          if (accept) begin
            len[7:0] <= in_data;
            state    <= ST_LEN1;
          end
        end
        ST_LEN1: begin
          if (accept) begin
            len[15:8] <= in_data;
            if (len_next == 16'd0)                state <= ST_CSUM;
            else if ({1'b0, len_next} > MAX_WORDS) state <= ST_ERROR;
            else                                   state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (accept) begin
            checksum <= checksum ^ in_data;
            if (word_ready) begin
              ram_addr   <= ADDRESS_WIDTH'(BASE_ADDR) + ADDRESS_WIDTH'(words_loaded);
              ram_dataIn <= word;
              state      <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          words_loaded <= words_next;
          state        <= (words_next == len) ? ST_CSUM : ST_DATA;
        end
        ST_CSUM: begin
          if (accept) state <= (in_data == checksum) ? ST_DONE : ST_ERROR;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == ST_LEN0) || (state == ST_LEN1) ||
                (state == ST_DATA) || (state == ST_CSUM);
    busy      = in_ready || (state == ST_WRITE);
    ram_wEn   = (state == ST_WRITE);
    done      = (state == ST_DONE);
    err       = (state == ST_ERROR);
    cpu_hold  = busy || err;
    fsm_state = state;
  end

endmodule
